// File: rtl/sar_result_collector.sv
// sar_result_collector
//   Captures each end-of-conversion code from the coarse/fine SAR logic,
//   optionally averages 2^AVG_LOG2 consecutive codes, and queues the results
//   in a small FIFO that drains over a valid/ready handshake.
//   Optional feature macro: SAR_RES_TIMESTAMP_EN. When it is defined, each
//   result word is prefixed with a free-running timestamp that is latched on
//   the final sample of the result.
//   i_rst is an asynchronous, active-low reset. i_clr is the synchronous clear.

module sar_result_collector #(
    parameter int N_BITS     = 10,
    parameter int AVG_LOG2   = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int TS_W       = 8,
`ifdef SAR_RES_TIMESTAMP_EN
    localparam int OUT_W     = N_BITS + TS_W,
`else
    localparam int OUT_W     = N_BITS,
`endif
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic [N_BITS-1:0] i_sar,
    input  logic              i_eoc,
    output logic [OUT_W-1:0]  o_dout,
    output logic              o_dout_valid,
    input  logic              i_dout_ready,
    output logic [LVL_W-1:0]  o_level,
    output logic              o_ovf
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ACC_W = N_BITS + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

    // Pointer arithmetic relies on natural wrap, so depth must be a power of two.
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (TS_W < 1)) begin : g_cfg_err
        $error("sar_result_collector: FIFO_DEPTH must be a power of two >= 2 and TS_W >= 1");
    end

    logic                r_eoc_d;
    logic [ACC_W-1:0]    r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic [OUT_W-1:0]    r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [LVL_W-1:0]    r_level;
    logic [OUT_W-1:0]    r_dout;
    logic                r_dout_valid;
    logic                r_ovf;

    logic                w_smp;
    logic [ACC_W-1:0]    w_sum;
    logic                w_last;
    logic [N_BITS-1:0]   w_result;
    logic [OUT_W-1:0]    w_word;
    logic                w_full;
    logic                w_pop;
    logic                w_push_req;
    logic                w_push;
    logic                w_drop;
    logic [LVL_W-1:0]    w_keep;
    logic [LVL_W-1:0]    w_level_nxt;
    logic [PTR_W-1:0]    w_rd_ptr_nxt;
    logic [OUT_W-1:0]    w_dout_nxt;

`ifdef SAR_RES_TIMESTAMP_EN
    logic [TS_W-1:0]     r_ts;

    // Free-running timestamp; the value seen on the final-sample edge is stored.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_ts <= {TS_W{1'b0}};
        end else begin
            r_ts <= r_ts + TS_W'(1);
        end
    end

    assign w_word = {r_ts, w_result};
`else
    assign w_word = w_result;
`endif

    // Rising edge of eoc while enabled is one sample; a held eoc counts once.
    assign w_smp      = i_en & i_eoc & ~r_eoc_d;
    assign w_sum      = r_acc + ACC_W'(i_sar);
    assign w_last     = (r_cnt == CNT_LAST);
    assign w_result   = N_BITS'(w_sum >> AVG_LOG2);

    assign w_full     = (r_level == LVL_FULL);
    assign w_pop      = r_dout_valid & i_dout_ready;
    assign w_push_req = w_smp & w_last;
    // A full FIFO still accepts a push when a pop frees the head slot.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;
    assign w_keep     = r_level - LVL_W'(w_pop);

    // Next occupancy, read pointer and head word for the registered output.
    always_comb begin
        w_level_nxt  = r_level;
        w_rd_ptr_nxt = r_rd_ptr;
        w_dout_nxt   = r_mem[r_rd_ptr];
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + LVL_W'(1);
            2'b01:   w_level_nxt = r_level - LVL_W'(1);
            default: w_level_nxt = r_level;
        endcase
        if (w_pop) begin
            w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
        end else begin
            w_rd_ptr_nxt = r_rd_ptr;
        end
        // With nothing left behind the head, the new word bypasses the memory.
        if (w_push && (w_keep == {LVL_W{1'b0}})) begin
            w_dout_nxt = w_word;
        end else begin
            w_dout_nxt = r_mem[w_rd_ptr_nxt];
        end
    end

    // Edge detector history and the averaging accumulator.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_eoc_d <= 1'b0;
            r_acc   <= {ACC_W{1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_eoc_d <= i_eoc;
            if (i_clr || !i_en) begin
                r_acc <= {ACC_W{1'b0}};
                r_cnt <= {CNT_W{1'b0}};
            end else if (w_smp) begin
                if (w_last) begin
                    r_acc <= {ACC_W{1'b0}};
                    r_cnt <= {CNT_W{1'b0}};
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_acc <= r_acc;
                r_cnt <= r_cnt;
            end
        end
    end

    // Result storage; written only when a push is accepted.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= {OUT_W{1'b0}};
            end
        end else if (!i_clr && w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end else begin
            r_mem <= r_mem;
        end
    end

    // FIFO control, registered head word and sticky overflow flag.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wr_ptr     <= {PTR_W{1'b0}};
            r_rd_ptr     <= {PTR_W{1'b0}};
            r_level      <= {LVL_W{1'b0}};
            r_dout       <= {OUT_W{1'b0}};
            r_dout_valid <= 1'b0;
            r_ovf        <= 1'b0;
        end else if (i_clr) begin
            r_wr_ptr     <= {PTR_W{1'b0}};
            r_rd_ptr     <= {PTR_W{1'b0}};
            r_level      <= {LVL_W{1'b0}};
            r_dout       <= {OUT_W{1'b0}};
            r_dout_valid <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_level      <= w_level_nxt;
            r_dout       <= w_dout_nxt;
            r_dout_valid <= (w_level_nxt != {LVL_W{1'b0}});
            r_ovf        <= r_ovf | w_drop;
        end
    end

    assign o_dout       = r_dout;
    assign o_dout_valid = r_dout_valid;
    assign o_level      = r_level;
    assign o_ovf        = r_ovf;

endmodule
